// File: rtl/unstripe_sched.sv
// unstripe_sched: two-lane byte unstriping scheduler on the fast clock clk_8f.
// A 3-bit phase counter derives the f (every 8 cycles) and 2f (every 4 cycles)
// strobes. Both lanes are sampled on the f strobe edge and replayed as one byte
// stream at the 2f rate: the lane-0 slot first, then the lane-1 slot.
//
// Optional feature: define UNSTRIPE_ERR_CNT_EN to add the saturating lane-error
// counter (parameter ERR_W and output err_count).
//
// Output semantics: valid_demux qualifies data_demux. Each 2f slot holds its
// byte for four clk_8f cycles. There is no back-pressure, so a slot is consumed
// whether or not the sink is looking. Invalid slots always carry data 0.
//
// Debug: dbg_state exposes the FSM state (0 IDLE, 1 SYNC, 2 RUN), and dbg_cnt
// exposes the phase counter.
module unstripe_sched #(
  parameter int DW = 8
`ifdef UNSTRIPE_ERR_CNT_EN
  , parameter int ERR_W = 4
`endif
) (
  input  logic          clk_8f,
  input  logic          rst,
  input  logic          enb,
  input  logic [DW-1:0] data_stripe_0,
  input  logic [DW-1:0] data_stripe_1,
  input  logic          valid_stripe_0,
  input  logic          valid_stripe_1,
  output logic [DW-1:0] data_demux,
  output logic          valid_demux,
  output logic          en_f,
  output logic          en_2f,
  output logic          sel_lane,
  output logic          lane_err,
`ifdef UNSTRIPE_ERR_CNT_EN
  output logic [ERR_W-1:0] err_count,
`endif
  output logic [1:0]    dbg_state,
  output logic [2:0]    dbg_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;

  // Hold registers: one f-period snapshot of both lanes
  logic [DW-1:0] hold0_data_q, hold0_data_d;
  logic          hold0_vld_q, hold0_vld_d;
  logic [DW-1:0] hold1_data_q, hold1_data_d;
  logic          hold1_vld_q, hold1_vld_d;

  // Registered output stage
  logic [DW-1:0] dout_q, dout_d;
  logic          vout_q, vout_d;
  logic          sel_q, sel_d;
  logic          lerr_q, lerr_d;

  logic          slot_f;
  logic          slot_2f;

  // Phase strobes are decoded straight from the counter
  assign slot_f  = (cnt_q == 3'd7);
  assign slot_2f = (cnt_q[1:0] == 2'd3);

  // FSM state register
  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: SYNC waits for a valid lane-0 byte, RUN falls back to SYNC
  // when a capture finds both lanes idle, and dropping enb always goes to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enb) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (!enb) begin
          state_d = ST_IDLE;
        end else if (slot_f && valid_stripe_0) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enb) begin
          state_d = ST_IDLE;
        end else if (slot_f && !valid_stripe_0 && !valid_stripe_1) begin
          state_d = ST_SYNC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: counter, lane capture, slot emission and mismatch detection
  always_comb begin
    cnt_d        = cnt_q;
    hold0_data_d = hold0_data_q;
    hold0_vld_d  = hold0_vld_q;
    hold1_data_d = hold1_data_q;
    hold1_vld_d  = hold1_vld_q;
    dout_d       = dout_q;
    vout_d       = vout_q;
    sel_d        = sel_q;
    lerr_d       = 1'b0;

    if (state_q == ST_IDLE || !enb) begin
      // Idle, or leaving for idle: discard everything pending
      cnt_d        = '0;
      hold0_data_d = '0;
      hold0_vld_d  = 1'b0;
      hold1_data_d = '0;
      hold1_vld_d  = 1'b0;
      dout_d       = '0;
      vout_d       = 1'b0;
      sel_d        = 1'b0;
    end else begin
      cnt_d = cnt_q + 3'd1;

      if (slot_2f) begin
        if (state_q == ST_RUN) begin
          if (slot_f) begin
            // Second half of the f period: lane 1 from the previous capture
            dout_d = hold1_vld_q ? hold1_data_q : '0;
            vout_d = hold1_vld_q;
            sel_d  = 1'b1;
          end else begin
            // First half of the f period: lane 0 from the latest capture
            dout_d = hold0_vld_q ? hold0_data_q : '0;
            vout_d = hold0_vld_q;
            sel_d  = 1'b0;
          end
        end else begin
          // Slots seen while searching for alignment are empty
          dout_d = '0;
          vout_d = 1'b0;
          sel_d  = 1'b0;
        end
      end

      // Capture in RUN unconditionally, or in SYNC once lane 0 is valid
      if (slot_f && (state_q == ST_RUN || valid_stripe_0)) begin
        hold0_data_d = data_stripe_0;
        hold0_vld_d  = valid_stripe_0;
        hold1_data_d = data_stripe_1;
        hold1_vld_d  = valid_stripe_1;
        lerr_d       = valid_stripe_0 ^ valid_stripe_1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      hold0_data_q <= '0;
      hold0_vld_q  <= 1'b0;
      hold1_data_q <= '0;
      hold1_vld_q  <= 1'b0;
      dout_q       <= '0;
      vout_q       <= 1'b0;
      sel_q        <= 1'b0;
      lerr_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hold0_data_q <= hold0_data_d;
      hold0_vld_q  <= hold0_vld_d;
      hold1_data_q <= hold1_data_d;
      hold1_vld_q  <= hold1_vld_d;
      dout_q       <= dout_d;
      vout_q       <= vout_d;
      sel_q        <= sel_d;
      lerr_q       <= lerr_d;
    end
  end

`ifdef UNSTRIPE_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Count mismatches on the same edge as the lane_err pulse, saturating at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (lerr_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register; survives IDLE and clears only on rst
  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign data_demux  = dout_q;
  assign valid_demux = vout_q;
  assign sel_lane    = sel_q;
  assign lane_err    = lerr_q;
  assign en_f        = slot_f;
  assign en_2f       = slot_2f;
  assign dbg_state   = state_q;
  assign dbg_cnt     = cnt_q;

endmodule
